// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the shared single-precision multiplier arbiter.
// Requests carry an operand pair; responses carry the product and the issuer's tag.
package fp_mul_pkg;

    localparam int FP_W      = 32;
    // Widest tag needed for up to 8 requesters.
    localparam int MAX_TAG_W = 3;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_req_t;

    typedef struct packed {
        logic [FP_W-1:0]      result;
        logic [MAX_TAG_W-1:0] tag;
    } fp_resp_t;

endpackage

// File: rtl/FPMultiplication.sv
// Combinational single-precision multiply: hidden bit forced, mantissa truncated,
// zero only for an all-zero operand, no NaN/Inf/denormal handling, exponent wraps.
module FPMultiplication (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [47:0] prod;
    logic [7:0]  exp_res;
    logic [22:0] mant;
    logic        unused_low;

    always_comb begin
        prod    = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        // 8-bit arithmetic gives the modulo-256 exponent wrap for free.
        exp_res = a[30:23] + b[30:23] - 8'd127 + {7'b0, prod[47]};
        mant    = prod[47] ? prod[46:24] : prod[45:23];
        if (a == 32'h0 || b == 32'h0) begin
            result = 32'h0;
        end else begin
            result = {a[31] ^ b[31], exp_res, mant};
        end
    end

    assign unused_low = ^prod[22:0];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one FP multiplier among N_REQ requesters through a
// two-stage (operand register, result register) valid/ready pipeline.
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_result,
    output logic [TAG_W-1:0]      resp_tag,
    input  logic                  resp_ready,
    output logic                  busy
);

    // Handshakes: a beat moves on any cycle where valid & ready are both high;
    // valid must not depend on ready, ready may depend on valid.

    logic             run_q, run_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             s1_valid_q, s1_valid_d;
    fp_req_t          s1_q, s1_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    fp_resp_t         s2_q, s2_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             grant_en;
    logic [N_REQ-1:0] grant;
    logic             xfer;
    logic [TAG_W-1:0] win;
    fp_req_t          win_req;
    logic [31:0]      product;
    logic             unused_tag;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (TAG_W)
    ) u_arb (
        .req   (req_valid),
        .en    (grant_en),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    FPMultiplication u_mul (
        .a      (s1_q.a),
        .b      (s1_q.b),
        .result (product)
    );

    always_comb begin
        s2_adv   = !s2_valid_q || resp_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        // run_q keeps grants off until the first edge after reset release.
        grant_en = s1_adv && run_q;
        xfer     = |grant;

        win     = '0;
        win_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win       = TAG_W'(i);
                win_req.a = req_a[i*32 +: 32];
                win_req.b = req_b[i*32 +: 32];
            end
        end

        run_d      = 1'b1;
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;

        if (xfer) begin
            rr_ptr_d = (win == TAG_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        end

        if (s2_adv) begin
            s2_valid_d  = s1_valid_q;
            s2_d.result = product;
            s2_d.tag    = MAX_TAG_W'(s1_tag_q);
        end

        if (s1_adv) begin
            s1_valid_d = xfer;
            if (xfer) begin
                s1_d     = win_req;
                s1_tag_d = win;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= 1'b0;
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            run_q      <= run_d;
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    assign req_ready   = grant;
    assign resp_valid  = s2_valid_q;
    assign resp_result = s2_q.result;
    assign resp_tag    = s2_q.tag[TAG_W-1:0];
    assign busy        = s1_valid_q || s2_valid_q;
    assign unused_tag  = ^s2_q.tag;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: expected responses are queued at issue time
// and a negedge monitor pops and compares every accepted response.
module tb_fp_mul_arbiter;

    localparam int N_REQ = 4;
    localparam int TAG_W = 2;
    localparam int W     = 32 + TAG_W;

    logic                clk;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic                resp_valid;
    logic [31:0]         resp_result;
    logic [TAG_W-1:0]    resp_tag;
    logic                resp_ready;
    logic                busy;

    logic [W-1:0] exp_q[$];
    logic [31:0]  exp_res[N_REQ];
    int           n_tests;
    int           n_fail;
    int           acc_cnt;
    int           resp_cnt;

    fp_mul_arbiter #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .resp_tag    (resp_tag),
        .resp_ready  (resp_ready),
        .busy        (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        if (!rst && resp_valid && resp_ready) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got %0h required none", {resp_result, resp_tag});
            end else begin
                exp_w = exp_q.pop_front();
                check("resp", 64'({resp_result, resp_tag}), 64'(exp_w));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            acc_cnt += $countones(req_valid & req_ready);
            check("grant_legal", 64'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)), 64'(1));
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int i, input string name);
        int  n;
        logic seen;
        logic [N_REQ-1:0] got;
        n    = 0;
        seen = 1'b0;
        got  = '0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (req_ready != '0) begin
                seen = 1'b1;
                got  = req_ready;
            end
            n++;
        end
        check(name, 64'(got), 64'(N_REQ'(1) << i));
        step();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        check(name, 64'((busy == 1'b0) && (exp_q.size() == 0)), 64'(1));
    endtask

    task automatic send_one(input int i, input string name);
        exp_q.push_back({exp_res[i], TAG_W'(i)});
        req_valid = N_REQ'(1) << i;
        wait_grant(i, name);
        req_valid = '0;
    endtask

    initial begin
        int streak;
        int rc0;
        int ac0;

        n_tests  = 0;
        n_fail   = 0;
        acc_cnt  = 0;
        resp_cnt = 0;
        // req3..req0 operand pairs: 4*-2, 0*3, 1.5*1.5, 2*3
        req_a = {32'h40800000, 32'h00000000, 32'h3FC00000, 32'h40000000};
        req_b = {32'hC0000000, 32'h40400000, 32'h3FC00000, 32'h40400000};
        exp_res[0] = 32'h40C00000;
        exp_res[1] = 32'h40100000;
        exp_res[2] = 32'h00000000;
        exp_res[3] = 32'hC1000000;

        rst        = 1'b1;
        req_valid  = 4'b0001;
        resp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_result", 64'(resp_result), 64'(0));
        check("rst_resp_tag", 64'(resp_tag), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", 64'(req_ready), 64'(0));
        req_valid = '0;
        step();

        // Single request with latency and busy checks
        exp_q.push_back({32'h40C00000, 2'd0});
        req_valid = 4'b0001;
        @(negedge clk);
        check("grant_single", 64'(req_ready), 64'(4'b0001));
        step();
        req_valid = '0;
        check("lat_s1_valid", 64'(resp_valid), 64'(0));
        check("lat_s1_busy", 64'(busy), 64'(1));
        step();
        check("lat_s2_valid", 64'(resp_valid), 64'(1));
        step();
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_resp_valid", 64'(resp_valid), 64'(0));

        // Zero operand, 1.5*1.5, negative product; leaves pointer at 0
        send_one(2, "grant_zero");
        wait_idle("drain_zero");
        send_one(1, "grant_1p5");
        send_one(3, "grant_neg");
        wait_idle("drain_single");

        // Round robin with all requesters valid
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({exp_res[k % N_REQ], TAG_W'(k % N_REQ)});
        end
        rc0       = resp_cnt;
        streak    = 0;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k >= 1 && resp_valid) streak++;
        end
        req_valid = '0;
        check("rr_back_to_back", 64'(streak), 64'(7));
        wait_idle("drain_rr");
        check("rr_resp_count", 64'(resp_cnt - rc0), 64'(8));

        // Backpressure with requesters 1 and 3
        ac0 = acc_cnt;
        exp_q.push_back({32'h40100000, 2'd1});
        exp_q.push_back({32'hC1000000, 2'd3});
        resp_ready = 1'b0;
        req_valid  = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k >= 1) begin
                check("bp_tag_stable", 64'(resp_tag), 64'(1));
                check("bp_result_stable", 64'(resp_result), 64'(32'h40100000));
            end
        end
        check("bp_ready_low", 64'(req_ready), 64'(0));
        check("bp_accept_count", 64'(acc_cnt - ac0), 64'(2));
        resp_ready = 1'b1;
        req_valid  = '0;
        wait_idle("drain_bp");
        check("bp_accept_final", 64'(acc_cnt - ac0), 64'(2));

        // Reset with both stages valid
        resp_ready = 1'b0;
        req_valid  = 4'b0101;
        step();
        step();
        step();
        req_valid = 4'b1111;
        check("mid_busy_before", 64'(busy), 64'(1));
        check("mid_valid_before", 64'(resp_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_resp_valid", 64'(resp_valid), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_req_ready", 64'(req_ready), 64'(0));
        step();
        step();
        rst        = 1'b0;
        resp_ready = 1'b1;
        exp_q.push_back({32'h40C00000, 2'd0});
        wait_grant(0, "post_rst_grant");
        req_valid = '0;
        wait_idle("drain_post_rst");

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
